// File: rtl/data_bus_ctrl.sv
// data_bus_ctrl: MEM-stage load/store bus sequencer, sized and extended loads.
// Optional DBC_MISALIGNED_SPLIT_EN: run 8-byte-line-crossing accesses as two beats.
module data_bus_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ir_mem,
    input  logic        mem_valid,
    input  logic        mem_adv,
    input  logic [63:0] addr,
    input  logic [63:0] st_data,
    output logic        b_rd,
    output logic        b_wr,
    output logic [63:0] ld_data,
    output logic        ma_err,
    output logic [63:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_be,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack
);

`ifdef DBC_MISALIGNED_SPLIT_EN
    localparam logic SPLIT = 1'b1;
`else
    localparam logic SPLIT = 1'b0;
`endif

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

    state_t state, state_nx;

    logic        is_ld_in, is_st_in, start, busy;
    logic        cross_in, cross_q, final_ack;
    logic [1:0]  sz_in, sz_q;
    logic        sgn_q, ld_q;
    logic [63:0] addr_q, st_q, beat0_q;
    logic [63:0] line_addr;
    logic [7:0]  bm;
    logic [15:0] mask16;
    logic [127:0] wd128, raw;
    logic [63:0] lv, ld_ext;
    logic        unused_ir;

    function automatic logic crosses(input logic [2:0] off, input logic [1:0] sz);
        return ({1'b0, off} + (4'd1 << sz)) > 4'd8;
    endfunction

    assign unused_ir = ^{ir_mem[31:15], ir_mem[11:7]};
    assign is_ld_in  = ir_mem[6:0] == OP_LOAD;
    assign is_st_in  = ir_mem[6:0] == OP_STORE;
    assign sz_in     = ir_mem[13:12];
    assign start     = (state == IDLE) && !rst && mem_valid && (is_ld_in || is_st_in);
    assign cross_in  = crosses(addr[2:0], sz_in);
    assign cross_q   = crosses(addr_q[2:0], sz_q);
    assign busy      = start || (state == ACC0) || (state == ACC1);
    assign b_rd      = busy && (start ? is_ld_in : ld_q);
    assign b_wr      = busy && (start ? is_st_in : !ld_q);
    assign line_addr = {addr_q[63:3], 3'b000};
    assign final_ack = mem_ack && (((state == ACC0) && !cross_q) || (state == ACC1));

    always_comb begin
        bm = 8'h00;
        unique case (sz_q)
            2'd0: bm = 8'h01;
            2'd1: bm = 8'h03;
            2'd2: bm = 8'h0F;
            2'd3: bm = 8'hFF;
            default: bm = 8'h00;
        endcase
    end

    assign mask16 = {8'h00, bm} << addr_q[2:0];
    assign wd128  = {64'd0, st_q} << {addr_q[2:0], 3'b000};

    // A crossing load's low bytes come from the beat captured in ACC0.
    always_comb begin
        raw    = (state == ACC1) ? {mem_rdata, beat0_q} : {64'd0, mem_rdata};
        lv     = 64'(raw >> {addr_q[2:0], 3'b000});
        ld_ext = lv;
        unique case (sz_q)
            2'd0: ld_ext = {{56{sgn_q & lv[7]}}, lv[7:0]};
            2'd1: ld_ext = {{48{sgn_q & lv[15]}}, lv[15:0]};
            2'd2: ld_ext = {{32{sgn_q & lv[31]}}, lv[31:0]};
            2'd3: ld_ext = lv;
            default: ld_ext = lv;
        endcase
    end

    always_comb begin
        state_nx  = state;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 64'd0;
        mem_be    = 8'h00;
        mem_wdata = 64'd0;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nx = (cross_in && !SPLIT) ? DONE : ACC0;
            end
            ACC0: begin
                mem_rd    = ld_q;
                mem_wr    = !ld_q;
                mem_addr  = line_addr;
                mem_be    = mask16[7:0];
                mem_wdata = wd128[63:0];
                if (mem_ack)
                    state_nx = cross_q ? ACC1 : DONE;
            end
            ACC1: begin
                mem_rd    = ld_q;
                mem_wr    = !ld_q;
                mem_addr  = line_addr + 64'd8;
                mem_be    = mask16[15:8];
                mem_wdata = wd128[127:64];
                if (mem_ack)
                    state_nx = DONE;
            end
            DONE: begin
                if (mem_adv)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= 64'd0;
            st_q    <= 64'd0;
            sz_q    <= 2'd0;
            sgn_q   <= 1'b0;
            ld_q    <= 1'b0;
            beat0_q <= 64'd0;
            ld_data <= 64'd0;
            ma_err  <= 1'b0;
        end else begin
            state  <= state_nx;
            ma_err <= start && cross_in && !SPLIT;
            if (start) begin
                addr_q <= addr;
                st_q   <= st_data;
                sz_q   <= sz_in;
                sgn_q  <= !ir_mem[14];
                ld_q   <= is_ld_in;
            end
            if ((state == ACC0) && mem_ack)
                beat0_q <= mem_rdata;
            if (final_ack && ld_q)
                ld_data <= ld_ext;
        end
    end

endmodule

// File: tb/tb_data_bus_ctrl.sv
// tb_data_bus_ctrl: randomized bench with a byte-addressed memory model.
// Define DBC_MISALIGNED_SPLIT_EN to match an RTL build with split enabled.
module tb_data_bus_ctrl;

`ifdef DBC_MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ir_mem;
    logic        mem_valid, mem_adv;
    logic [63:0] addr, st_data;
    logic        b_rd, b_wr, ma_err, mem_rd, mem_wr;
    logic [63:0] ld_data, mem_addr, mem_wdata;
    logic [7:0]  mem_be;
    logic [63:0] mem_rdata = 64'd0;
    logic        mem_ack = 1'b0;

    int errs = 0;
    int checks = 0;

    data_bus_ctrl dut (
        .clk(clk), .rst(rst), .ir_mem(ir_mem), .mem_valid(mem_valid),
        .mem_adv(mem_adv), .addr(addr), .st_data(st_data),
        .b_rd(b_rd), .b_wr(b_wr), .ld_data(ld_data), .ma_err(ma_err),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // Byte memory; untouched bytes read back a fixed hash of their address.
    logic [7:0] mem [logic [63:0]];

    function automatic logic [7:0] rd_byte(input logic [63:0] a);
        logic [7:0] h;
        if (mem.exists(a)) return mem[a];
        h = a[7:0] * 8'd37;
        h = h ^ a[15:8] ^ 8'h5A;
        return h;
    endfunction

    function automatic logic [31:0] mk_ir(input bit ld, input logic [2:0] f3);
        logic [31:0] ir;
        ir = $urandom;
        ir[14:12] = f3;
        ir[6:0] = ld ? 7'b0000011 : 7'b0100011;
        return ir;
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] a, input logic [2:0] f3);
        int n;
        logic [63:0] v;
        n = 1 << f3[1:0];
        v = 64'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = rd_byte(a + 64'(i));
        if (!f3[2] && v[8*n-1])
            for (int i = 8 * n; i < 64; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic bit model_cross(input logic [63:0] a, input int n);
        return (int'(a[2:0]) + n) > 8;
    endfunction

    function automatic logic [7:0] exp_be(input logic [63:0] a, input int n, input int k);
        logic [7:0] b;
        int r;
        b = 8'h00;
        for (int j = 0; j < 8; j++) begin
            r = 8 * k + j - int'(a[2:0]);
            if (r >= 0 && r < n) b[j] = 1'b1;
        end
        return b;
    endfunction

    // Bus responder: per-beat ack delay from dly_q, optional spurious acks when idle.
    int dly_q[$];
    int cur_dly, cnt, acks, req_cycles;
    bit in_beat = 1'b0;
    bit hold_ack = 1'b0;
    bit spur = 1'b0;
    logic [63:0] bq_addr[$];
    logic [7:0]  bq_be[$];
    logic [63:0] bq_wd[$];
    logic [63:0] p_addr, p_wdata;
    logic [7:0]  p_be;
    logic        p_rd, p_wr;

    always @(negedge clk) begin
        if (rst) begin
            mem_ack = 1'b0;
            in_beat = 1'b0;
        end else if (mem_rd || mem_wr) begin
            req_cycles++;
            if (!in_beat) begin
                in_beat = 1'b1;
                cnt = 0;
                cur_dly = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
            end else begin
                checks++;
                if (mem_addr !== p_addr || mem_be !== p_be || mem_wdata !== p_wdata ||
                    mem_rd !== p_rd || mem_wr !== p_wr) begin
                    errs++;
                    $display("FAIL bus_hold: addr=%h be=%h got, required addr=%h be=%h",
                             mem_addr, mem_be, p_addr, p_be);
                end
            end
            p_addr = mem_addr; p_be = mem_be; p_wdata = mem_wdata;
            p_rd = mem_rd; p_wr = mem_wr;
            if (!hold_ack && cnt >= cur_dly) begin
                mem_ack = 1'b1;
                for (int j = 0; j < 8; j++)
                    mem_rdata[8*j +: 8] = rd_byte({mem_addr[63:3], 3'b000} + 64'(j));
                if (mem_wr)
                    for (int j = 0; j < 8; j++)
                        if (mem_be[j])
                            mem[{mem_addr[63:3], 3'b000} + 64'(j)] = mem_wdata[8*j +: 8];
                acks++;
                bq_addr.push_back(mem_addr);
                bq_be.push_back(mem_be);
                bq_wd.push_back(mem_wdata);
                in_beat = 1'b0;
            end else begin
                mem_ack = 1'b0;
                cnt++;
            end
        end else begin
            in_beat = 1'b0;
            mem_ack = spur ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = {$urandom, $urandom};
        end
    end

    // Observations from one access, filled in by run_access.
    logic        o_start_rd, o_start_wr, o_to, o_done_req, o_ld_moved;
    int          o_busy, o_ma;
    logic [63:0] o_ld;
    logic [63:0] exp_ld = 64'd0;

    // Drives one access; enters and leaves at posedge+1, samples at posedge+2.
    task automatic run_access(input logic [31:0] ir, input logic [63:0] a,
                              input logic [63:0] sd, input int d0, input int d1,
                              input int hold);
        bit fin;
        dly_q.delete();
        dly_q.push_back(d0);
        dly_q.push_back(d1);
        bq_addr.delete(); bq_be.delete(); bq_wd.delete();
        acks = 0; req_cycles = 0;
        ir_mem = ir; addr = a; st_data = sd; mem_valid = 1'b1; mem_adv = 1'b0;
        #1;
        o_start_rd = b_rd; o_start_wr = b_wr;
        o_busy = 0; o_ma = 0; o_to = 1'b0; o_done_req = 1'b0; o_ld_moved = 1'b0;
        fin = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (b_rd || b_wr) o_busy++;
            if (ma_err) o_ma++;
            if (!(b_rd || b_wr)) begin
                fin = 1'b1;
                break;
            end
            @(posedge clk); #2;
        end
        if (!fin) o_to = 1'b1;
        o_ld = ld_data;
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #2;
            if (mem_rd || mem_wr || b_rd || b_wr) o_done_req = 1'b1;
            if (ma_err) o_ma++;
            if (ld_data !== o_ld) o_ld_moved = 1'b1;
        end
        mem_adv = 1'b1;
        @(posedge clk); #1;
        mem_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; mem_valid = 1'b1; mem_adv = 1'b1;
        ir_mem = mk_ir(1'b1, 3'd3); addr = 64'h1000; st_data = 64'd0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({b_rd, b_wr, mem_rd, mem_wr, ma_err} !== 5'b0) begin
            errs++;
            $display("FAIL reset_ctl: b_rd,b_wr,rd,wr,ma=%b required 00000",
                     {b_rd, b_wr, mem_rd, mem_wr, ma_err});
        end
        checks++;
        if (mem_be !== 8'h00 || mem_addr !== 64'd0) begin
            errs++;
            $display("FAIL reset_bus: be=%h addr=%h required 0", mem_be, mem_addr);
        end
        checks++;
        if (ld_data !== 64'd0) begin
            errs++;
            $display("FAIL reset_ld: ld_data=%h required 0", ld_data);
        end
        mem_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_ld_aligned;
        logic [63:0] w;
        w = 64'h1122334455667788;
        for (int i = 0; i < 8; i++) mem[64'h1000 + 64'(i)] = w[8*i +: 8];
        run_access(mk_ir(1'b1, 3'd3), 64'h1000, 64'd0, 0, 0, 1);
        checks++;
        if (o_ld !== 64'h1122334455667788 || o_to) begin
            errs++;
            $display("FAIL ld_aligned: ld_data=%h to=%b required 1122334455667788", o_ld, o_to);
        end
        checks++;
        if (o_busy != 2 || !o_start_rd || o_start_wr) begin
            errs++;
            $display("FAIL ld_busy: busy=%0d start_rd=%b required 2 1", o_busy, o_start_rd);
        end
        checks++;
        if (acks != 1 || (bq_addr.size() > 0 ? bq_addr[0] : 64'hx) !== 64'h1000 ||
            (bq_be.size() > 0 ? bq_be[0] : 8'hx) !== 8'hFF) begin
            errs++;
            $display("FAIL ld_beat: acks=%0d required 1 at 1000 be ff", acks);
        end
        exp_ld = 64'h1122334455667788;
    endtask

    task automatic test_lb_lbu;
        int d;
        mem[64'h1007] = 8'h80;
        d = $urandom_range(0, 3);
        run_access(mk_ir(1'b1, 3'd0), 64'h1007, 64'd0, d, 0, 1);
        checks++;
        if (o_ld !== 64'hFFFFFFFFFFFFFF80) begin
            errs++;
            $display("FAIL lb_sext: ld_data=%h required ffffffffffffff80", o_ld);
        end
        checks++;
        if (o_busy != 2 + d || (bq_be.size() > 0 ? bq_be[0] : 8'hx) !== 8'h80) begin
            errs++;
            $display("FAIL lb_be: busy=%0d required %0d, be=80", o_busy, 2 + d);
        end
        run_access(mk_ir(1'b1, 3'd4), 64'h1007, 64'd0, 0, 0, 0);
        checks++;
        if (o_ld !== 64'h0000000000000080) begin
            errs++;
            $display("FAIL lbu_zext: ld_data=%h required 0000000000000080", o_ld);
        end
        exp_ld = 64'h80;
    endtask

    task automatic test_sw_cross;
        int d0, d1;
        logic [63:0] w0, w1;
        logic [7:0] pre [4];
        for (int i = 0; i < 4; i++) pre[i] = rd_byte(64'h1006 + 64'(i));
        d0 = $urandom_range(0, 2);
        d1 = $urandom_range(0, 2);
        run_access(mk_ir(1'b0, 3'd2), 64'h1006, {$urandom, 32'hAABBCCDD}, d0, d1, 2);
        w0 = (bq_wd.size() > 0) ? bq_wd[0] : 64'hx;
        w1 = (bq_wd.size() > 1) ? bq_wd[1] : 64'hx;
        checks++;
        if (!o_start_wr || o_start_rd || o_to) begin
            errs++;
            $display("FAIL sw_start: b_wr=%b b_rd=%b required 1 0", o_start_wr, o_start_rd);
        end
        if (SPLIT) begin
            checks++;
            if (acks != 2 || bq_addr[0] !== 64'h1000 || bq_be[0] !== 8'hC0 ||
                w0[63:48] !== 16'hCCDD) begin
                errs++;
                $display("FAIL sw_beat0: acks=%0d wdata=%h required 2 beats, be c0, ccdd", acks, w0);
            end
            checks++;
            if (bq_addr[1] !== 64'h1008 || bq_be[1] !== 8'h03 || w1[15:0] !== 16'hAABB) begin
                errs++;
                $display("FAIL sw_beat1: addr=%h be=%h wdata=%h required 1008 03 aabb",
                         bq_addr[1], bq_be[1], w1);
            end
            checks++;
            if (o_busy != 3 + d0 + d1 || o_ma != 0) begin
                errs++;
                $display("FAIL sw_busy: busy=%0d ma=%0d required %0d 0", o_busy, o_ma, 3 + d0 + d1);
            end
            checks++;
            if ({rd_byte(64'h1009), rd_byte(64'h1008), rd_byte(64'h1007), rd_byte(64'h1006)}
                !== 32'hAABBCCDD) begin
                errs++;
                $display("FAIL sw_mem: memory does not hold aabbccdd at 1006");
            end
        end else begin
            checks++;
            if (o_ma != 1 || o_busy != 1) begin
                errs++;
                $display("FAIL sw_ma: ma_cycles=%0d busy=%0d required 1 1", o_ma, o_busy);
            end
            checks++;
            if (req_cycles != 0 || acks != 0) begin
                errs++;
                $display("FAIL sw_nobus: req_cycles=%0d required 0", req_cycles);
            end
            checks++;
            if (rd_byte(64'h1006) !== pre[0] || rd_byte(64'h1009) !== pre[3]) begin
                errs++;
                $display("FAIL sw_mem_kept: memory modified by rejected store");
            end
        end
        checks++;
        if (ld_data !== exp_ld) begin
            errs++;
            $display("FAIL sw_ld_kept: ld_data=%h required %h", ld_data, exp_ld);
        end
    endtask

    task automatic test_done_hold;
        logic [63:0] a, e;
        a = {$urandom, $urandom} & ~64'h7;
        e = model_load(a, 3'd3);
        spur = 1'b1;
        run_access(mk_ir(1'b1, 3'd3), a, 64'd0, 0, 0, 5);
        checks++;
        if (o_done_req || o_ld_moved || o_ld !== e) begin
            errs++;
            $display("FAIL done_hold: req=%b moved=%b ld=%h required 0 0 %h",
                     o_done_req, o_ld_moved, o_ld, e);
        end
        exp_ld = e;
        e = model_load(a + 64'd4, 3'd2);
        run_access(mk_ir(1'b1, 3'd2), a + 64'd4, 64'd0, 1, 0, 0);
        checks++;
        if (!o_start_rd || o_ld !== e) begin
            errs++;
            $display("FAIL done_release: start_rd=%b ld=%h required 1 %h", o_start_rd, o_ld, e);
        end
        exp_ld = e;
        spur = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [63:0] e;
        dly_q.delete();
        acks = 0;
        hold_ack = 1'b1;
        ir_mem = mk_ir(1'b1, 3'd3); addr = 64'h2000; mem_valid = 1'b1; mem_adv = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        checks++;
        if (!mem_rd || !b_rd) begin
            errs++;
            $display("FAIL rst_mid_pre: mem_rd=%b b_rd=%b required 1 1", mem_rd, b_rd);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mem_rd || b_rd || ld_data !== 64'd0) begin
            errs++;
            $display("FAIL rst_mid: mem_rd=%b b_rd=%b ld=%h required 0 0 0", mem_rd, b_rd, ld_data);
        end
        mem_valid = 1'b0; hold_ack = 1'b0; mem_adv = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ld = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (acks != 0 || ld_data !== 64'd0 || mem_rd) begin
            errs++;
            $display("FAIL rst_abandon: acks=%0d ld=%h required 0 0", acks, ld_data);
        end
        e = model_load(64'h2000, 3'd3);
        run_access(mk_ir(1'b1, 3'd3), 64'h2000, 64'd0, 0, 0, 0);
        checks++;
        if (!o_start_rd || o_ld !== e || o_busy != 2) begin
            errs++;
            $display("FAIL rst_recover: start=%b ld=%h busy=%0d required 1 %h 2",
                     o_start_rd, o_ld, o_busy, e);
        end
        exp_ld = e;
    endtask

    task automatic test_random;
        bit ld, cr, skip;
        logic [2:0] f3;
        logic [63:0] a, sd, e;
        logic [7:0] pre [8];
        logic [7:0] pre_lo, pre_hi, got;
        int n, d0, d1, hold, beats, ebusy;
        spur = 1'b1;
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                mem_valid = 1'($urandom_range(0, 1));
                ir_mem = mk_ir(1'b1, 3'd3);
                if (mem_valid) ir_mem[6:0] = 7'b0110011;
                #1;
                @(posedge clk); #1;
                checks++;
                if (b_rd || b_wr || mem_rd || mem_wr) begin
                    errs++;
                    $display("FAIL rnd_nomem: b_rd=%b b_wr=%b rd=%b wr=%b required 0",
                             b_rd, b_wr, mem_rd, mem_wr);
                end
                mem_valid = 1'b0;
                continue;
            end
            ld = 1'($urandom_range(0, 1));
            f3 = ld ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 3));
            n = 1 << f3[1:0];
            a = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) a = a & ~64'(n - 1);
            sd = {$urandom, $urandom};
            d0 = $urandom_range(0, 3);
            d1 = $urandom_range(0, 3);
            hold = $urandom_range(0, 2);
            cr = model_cross(a, n);
            skip = cr && !SPLIT;
            beats = skip ? 0 : (cr ? 2 : 1);
            ebusy = skip ? 1 : 1 + (d0 + 1) + (cr ? d1 + 1 : 0);
            e = model_load(a, f3);
            for (int i = 0; i < 8; i++) pre[i] = rd_byte(a + 64'(i));
            pre_lo = rd_byte(a - 64'd1);
            pre_hi = rd_byte(a + 64'(n));
            run_access(mk_ir(ld, f3), a, sd, d0, d1, hold);
            checks++;
            if (o_to || o_busy != ebusy || {o_start_rd, o_start_wr} !== {ld, !ld}) begin
                errs++;
                $display("FAIL rnd_busy: it=%0d busy=%0d start=%b%b required %0d %b%b",
                         it, o_busy, o_start_rd, o_start_wr, ebusy, ld, !ld);
            end
            checks++;
            if (acks != beats || o_ma != (skip ? 1 : 0) || o_done_req) begin
                errs++;
                $display("FAIL rnd_beats: it=%0d acks=%0d ma=%0d req=%b required %0d %0d 0",
                         it, acks, o_ma, o_done_req, beats, skip ? 1 : 0);
            end
            for (int k = 0; k < beats && k < acks; k++) begin
                checks++;
                if (bq_be[k] !== exp_be(a, n, k) ||
                    bq_addr[k] !== ({a[63:3], 3'b000} + 64'(8 * k))) begin
                    errs++;
                    $display("FAIL rnd_be: it=%0d beat=%0d be=%h addr=%h required %h %h", it, k,
                             bq_be[k], bq_addr[k], exp_be(a, n, k), {a[63:3], 3'b000} + 64'(8 * k));
                end
            end
            if (ld && !skip) exp_ld = e;
            checks++;
            if (o_ld !== exp_ld || ld_data !== exp_ld) begin
                errs++;
                $display("FAIL rnd_ld: it=%0d ld=%h required %h", it, o_ld, exp_ld);
            end
            if (!ld) begin
                for (int i = 0; i < n; i++) begin
                    got = rd_byte(a + 64'(i));
                    checks++;
                    if (got !== (skip ? pre[i] : sd[8*i +: 8])) begin
                        errs++;
                        $display("FAIL rnd_st: it=%0d byte=%0d mem=%h required %h", it, i, got,
                                 skip ? pre[i] : sd[8*i +: 8]);
                    end
                end
                checks++;
                if (rd_byte(a - 64'd1) !== pre_lo || rd_byte(a + 64'(n)) !== pre_hi) begin
                    errs++;
                    $display("FAIL rnd_st_edge: it=%0d neighbour byte modified", it);
                end
            end
        end
        spur = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ld_aligned();
        test_lb_lbu();
        test_sw_cross();
        test_done_hold();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/data_bus_ctrl.md
DATA_BUS_CTRL -- requirements
Module: data_bus_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 ir_mem  in  32  instruction in MEM; opcode [6:0], funct3 [14:12].
REQ-005 mem_valid  in  1  ir_mem is a real instruction, not a bubble.
REQ-006 mem_adv  in  1  MEM advances this edge (= !stall_mem).
REQ-007 addr  in  64  effective byte address.
REQ-008 st_data  in  64  store data, right-justified.
REQ-009 b_rd  out  1  load busy; stall request to control unit.
REQ-010 b_wr  out  1  store busy; stall request to control unit.
REQ-011 ld_data  out  64  extended load result, registered.
REQ-012 ma_err  out  1  one-cycle pulse: unsupported misaligned access.
REQ-013 mem_addr  out  64  8-byte-aligned bus address.
REQ-014 mem_rd / mem_wr  out  1 each  bus read / write request, held until ack.
REQ-015 mem_be  out  8  byte enables; mem_wdata  out  64  lane-aligned write data.
REQ-016 mem_rdata  in  64; mem_ack  in  1  beat complete, sampled on clk.

Function
REQ-017 Load = opcode 0000011 (LB/LH/LW/LD/LBU/LHU/LWU); store = opcode 0100011 (SB/SH/SW/SD).
REQ-018 States: IDLE, ACC0, ACC1, DONE.
REQ-019 start = IDLE && mem_valid && (load||store); on start go to ACC0, latching addr, size, sign, op and st_data.
REQ-020 b_rd = load && (start || ACC0 || ACC1); b_wr = store && (start || ACC0 || ACC1); both 0 in DONE and when idle.
REQ-021 size = 1/2/4/8 bytes; off = addr[2:0]; cross = off+size > 8.
REQ-022 ACC0: mem_addr = {addr[63:3],3'b0}, mem_be = low bytes of ((2^size-1) << off), mem_wdata = st_data << 8*off.
REQ-023 ACC0 + mem_ack: cross -> ACC1, else -> DONE; no ack -> hold every bus output unchanged.
REQ-024 ACC1: mem_addr = ACC0 address + 8, mem_be = bits [15:8] of the shifted mask, mem_wdata = upper bytes of the 128-bit shifted store data; ack -> DONE.
REQ-025 Load result: {beat1,beat0} >> 8*off, truncated to size, sign- or zero-extended per funct3; registered into ld_data on the final ack.
REQ-026 DONE: mem_adv -> IDLE; otherwise hold. ld_data stays stable until the next load's final ack.
REQ-027 mem_ack is ignored in IDLE and DONE.
REQ-028 Minimum latency is busy for 2 cycles: start at T, ACC0 with ack at T+1, DONE at T+2.

Reset
REQ-029 rst SHALL asynchronously force IDLE, b_rd=b_wr=mem_rd=mem_wr=ma_err=0, mem_be=0, mem_addr=0, ld_data=0.
REQ-030 rst mid-ACC0/ACC1 SHALL abandon the access with no completion and no ld_data update.

Configuration
REQ-031 Macro DBC_MISALIGNED_SPLIT_EN defined: crossing accesses run as two beats (ACC0 -> ACC1).
REQ-032 Macro not defined: a crossing start pulses ma_err for one cycle, goes straight to DONE, issues no bus request and leaves ld_data unchanged. Non-crossing accesses behave identically either way.

Verification
REQ-033 LD at 0x1000, ack on first ACC0 cycle, rdata 0x1122334455667788 -> ld_data=0x1122334455667788; b_rd high exactly 2 cycles.
REQ-034 LB at 0x1007, rdata[63:56]=0x80 -> ld_data=0xFFFFFFFFFFFFFF80; LBU at the same address -> 0x0000000000000080; mem_be=0x80.
REQ-035 Macro on: SW 0xAABBCCDD at 0x1006 -> beat0 addr 0x1000, be 0xC0, wdata[63:48]=0xCCDD; beat1 addr 0x1008, be 0x03, wdata[15:0]=0xAABB; b_wr high until the second ack.
REQ-036 Macro off: same SW -> ma_err one cycle, mem_wr never asserted, DONE reached the next cycle.
REQ-037 rst asserted mid-ACC0 with ack withheld -> mem_rd drops immediately, state IDLE, ld_data=0.
REQ-038 DONE with mem_adv=0 for 5 cycles -> no new request, b_rd=0 and ld_data stable; mem_adv=1 -> IDLE next cycle.
